// File: rtl/sdhci_obi_reg_bridge.sv
// sdhci_obi_reg_bridge: OBI subordinate that converts one OBI transaction at a
// time into a single register access with a ready handshake toward the SDHCI
// register file. Out-of-window addresses and empty byte enables are answered
// locally without a register access.
// Optional feature: define SDHCI_OBI_BRIDGE_TIMEOUT_EN to abort register
// accesses that stall for TimeoutCycles cycles.

package sdhci_obi_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

module sdhci_obi_reg_bridge #(
    parameter type         obi_req_t     = sdhci_obi_pkg::obi_req_t,
    parameter type         obi_rsp_t     = sdhci_obi_pkg::obi_rsp_t,
    parameter int unsigned AddrWidth     = 8,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  obi_req_t             obi_req_i,
    output obi_rsp_t             obi_rsp_o,
    output logic                 reg_req_o,
    output logic [AddrWidth-1:0] reg_addr_o,
    output logic                 reg_we_o,
    output logic [3:0]           reg_be_o,
    output logic [31:0]          reg_wdata_o,
    input  logic                 reg_ready_i,
    input  logic [31:0]          reg_rdata_i,
    input  logic                 reg_error_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    state_e                 state_r;
    state_e                 state_s;

    logic                   gnt_s;
    logic                   out_of_win_s;
    logic                   timeout_s;
    logic                   load_rsp_s;
    logic [31:0]            rsp_rdata_s;
    logic                   rsp_err_s;
    logic                   unused_s;

    logic                   reg_req_r;
    logic [AddrWidth-1:2]   reg_addr_r;
    logic                   reg_we_r;
    logic [3:0]             reg_be_r;
    logic [31:0]            reg_wdata_r;
    logic                   rvalid_r;
    logic [31:0]            rdata_r;
    logic                   err_r;

    // Grant only in IDLE, and never while reset is held.
    assign gnt_s        = (state_r == ST_IDLE) && obi_req_i.req && !rst_i;
    assign out_of_win_s = |obi_req_i.a.addr[31:AddrWidth];

`ifdef SDHCI_OBI_BRIDGE_TIMEOUT_EN
    localparam int unsigned CntWidth =
        ($clog2(TimeoutCycles + 1) > 8) ? $clog2(TimeoutCycles + 1) : 8;
    // Abort is taken in the stalled cycle that would bring the count to the limit,
    // so reg_req_o is high for exactly TimeoutCycles cycles.
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] tmo_cnt_r;

    // Watchdog: zero outside ACCESS, counts ACCESS cycles without reg_ready_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_r <= {CntWidth{1'b0}};
        end else if (state_r != ST_ACCESS) begin
            tmo_cnt_r <= {CntWidth{1'b0}};
        end else if (!reg_ready_i) begin
            tmo_cnt_r <= tmo_cnt_r + CntWidth'(1);
        end
    end

    assign timeout_s = (state_r == ST_ACCESS) && !reg_ready_i && (tmo_cnt_r == CntLast);
    assign unused_s  = ^obi_req_i.a.addr[1:0];
`else
    assign timeout_s = 1'b0;
    assign unused_s  = ^{obi_req_i.a.addr[1:0], 32'(TimeoutCycles)};
`endif

    // Next-state and response-result selection.
    always_comb begin
        state_s     = state_r;
        load_rsp_s  = 1'b0;
        rsp_rdata_s = 32'h0000_0000;
        rsp_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gnt_s) begin
                    if (out_of_win_s) begin
                        state_s    = ST_RESP;
                        load_rsp_s = 1'b1;
                        rsp_err_s  = 1'b1;
                    end else if (obi_req_i.a.be == 4'b0000) begin
                        state_s    = ST_RESP;
                        load_rsp_s = 1'b1;
                    end else begin
                        state_s = ST_ACCESS;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (reg_ready_i) begin
                    state_s     = ST_RESP;
                    load_rsp_s  = 1'b1;
                    rsp_rdata_s = reg_we_r ? 32'h0000_0000 : reg_rdata_i;
                    rsp_err_s   = reg_error_i;
                end else if (timeout_s) begin
                    state_s     = ST_RESP;
                    load_rsp_s  = 1'b1;
                    rsp_rdata_s = 32'hDEAD_BEEF;
                    rsp_err_s   = 1'b1;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Register-side request: fields latched at grant stay stable through ACCESS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_req_r   <= 1'b0;
            reg_addr_r  <= {(AddrWidth-2){1'b0}};
            reg_we_r    <= 1'b0;
            reg_be_r    <= 4'b0000;
            reg_wdata_r <= 32'h0000_0000;
        end else begin
            reg_req_r <= (state_s == ST_ACCESS);
            if (gnt_s) begin
                reg_addr_r  <= obi_req_i.a.addr[AddrWidth-1:2];
                reg_we_r    <= obi_req_i.a.we;
                reg_be_r    <= obi_req_i.a.be;
                reg_wdata_r <= obi_req_i.a.wdata;
            end
        end
    end

    // OBI response beat: rvalid for the RESP cycle, rdata/err hold between beats.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0000_0000;
            err_r    <= 1'b0;
        end else begin
            rvalid_r <= (state_s == ST_RESP);
            if (load_rsp_s) begin
                rdata_r <= rsp_rdata_s;
                err_r   <= rsp_err_s;
            end
        end
    end

    // Pack the OBI response.
    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = gnt_s;
        obi_rsp_o.rvalid  = rvalid_r;
        obi_rsp_o.r.rdata = rdata_r;
        obi_rsp_o.r.err   = err_r;
    end

    assign reg_req_o   = reg_req_r;
    assign reg_addr_o  = {reg_addr_r, 2'b00};
    assign reg_we_o    = reg_we_r;
    assign reg_be_o    = reg_be_r;
    assign reg_wdata_o = reg_wdata_r;

endmodule

// File: tb/tb_sdhci_obi_reg_bridge.sv
// Directed self-checking bench for sdhci_obi_reg_bridge.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the
// falling edge.
module tb_sdhci_obi_reg_bridge;

    import sdhci_obi_pkg::*;

    logic        clk_i;
    logic        rst_i;
    obi_req_t    obi_req;
    obi_rsp_t    obi_rsp;
    logic        reg_req_o;
    logic [7:0]  reg_addr_o;
    logic        reg_we_o;
    logic [3:0]  reg_be_o;
    logic [31:0] reg_wdata_o;
    logic        reg_ready_i;
    logic [31:0] reg_rdata_i;
    logic        reg_error_i;

    int n_checks;
    int n_fail;

    sdhci_obi_reg_bridge #(
        .AddrWidth     (8),
        .TimeoutCycles (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .obi_req_i   (obi_req),
        .obi_rsp_o   (obi_rsp),
        .reg_req_o   (reg_req_o),
        .reg_addr_o  (reg_addr_o),
        .reg_we_o    (reg_we_o),
        .reg_be_o    (reg_be_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_ready_i (reg_ready_i),
        .reg_rdata_i (reg_rdata_i),
        .reg_error_i (reg_error_i)
    );

    // Free-running clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Global time limit.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "bench time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One transaction; called at posedge+1. delay = ACCESS cycles with ready low.
    task automatic run_txn(input string nm, input logic [31:0] addr, input logic we,
                           input logic [3:0] be, input logic [31:0] wdata, input int delay,
                           input logic [31:0] rdata_in, input logic err_in, input logic filtered,
                           input logic [31:0] exp_rdata, input logic exp_err);
        logic [7:0] exp_addr;
        exp_addr          = addr[7:0] & 8'hFC;
        obi_req.req       = 1'b1;
        obi_req.a.addr    = addr;
        obi_req.a.we      = we;
        obi_req.a.be      = be;
        obi_req.a.wdata   = wdata;
        reg_rdata_i       = rdata_in;
        reg_error_i       = err_in;
        reg_ready_i       = 1'b0;
        @(negedge clk_i);
        check_eq({nm, ".gnt"}, 32'(obi_rsp.gnt), 32'd1);
        check_eq({nm, ".rvalid_at_gnt"}, 32'(obi_rsp.rvalid), 32'd0);
        step();
        obi_req.req = 1'b0;
        if (!filtered) begin
            for (int k = 0; k <= delay; k++) begin
                reg_ready_i = (k == delay);
                @(negedge clk_i);
                check_eq({nm, ".reg_req"},   32'(reg_req_o),   32'd1);
                check_eq({nm, ".reg_addr"},  32'(reg_addr_o),  32'(exp_addr));
                check_eq({nm, ".reg_we"},    32'(reg_we_o),    32'(we));
                check_eq({nm, ".reg_be"},    32'(reg_be_o),    32'(be));
                check_eq({nm, ".reg_wdata"}, reg_wdata_o,      wdata);
                check_eq({nm, ".rvalid_early"}, 32'(obi_rsp.rvalid), 32'd0);
                step();
            end
            reg_ready_i = 1'b0;
        end
        @(negedge clk_i);
        check_eq({nm, ".rvalid"},      32'(obi_rsp.rvalid),  32'd1);
        check_eq({nm, ".rdata"},       obi_rsp.r.rdata,      exp_rdata);
        check_eq({nm, ".err"},         32'(obi_rsp.r.err),   32'(exp_err));
        check_eq({nm, ".reg_req_rsp"}, 32'(reg_req_o),       32'd0);
        step();
        @(negedge clk_i);
        check_eq({nm, ".rvalid_drop"}, 32'(obi_rsp.rvalid),  32'd0);
        check_eq({nm, ".rdata_hold"},  obi_rsp.r.rdata,      exp_rdata);
        check_eq({nm, ".err_hold"},    32'(obi_rsp.r.err),   32'(exp_err));
        step();
    endtask

    // Hold req high and measure the distance between the first two grants.
    task automatic grant_gap(input string nm, input logic [3:0] be, input int exp_gap);
        int first;
        int second;
        first           = -1;
        second          = -1;
        obi_req.req     = 1'b1;
        obi_req.a.addr  = 32'h0000_0010;
        obi_req.a.we    = 1'b1;
        obi_req.a.be    = be;
        obi_req.a.wdata = 32'h5A5A_0001;
        reg_ready_i     = 1'b1;
        reg_error_i     = 1'b0;
        for (int cyc = 0; cyc < 12 && second < 0; cyc++) begin
            @(negedge clk_i);
            if (obi_rsp.gnt) begin
                if (first < 0) begin
                    first = cyc;
                end else begin
                    second = cyc;
                end
            end
            step();
        end
        obi_req.req = 1'b0;
        check_eq({nm, ".first_gnt"}, 32'(first), 32'd0);
        check_eq({nm, ".gnt_gap"},   32'(second - first), 32'(exp_gap));
        repeat (4) step();
        reg_ready_i = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_i       = 1'b1;
        obi_req     = '0;
        reg_ready_i = 1'b0;
        reg_rdata_i = 32'h0000_0000;
        reg_error_i = 1'b0;

        // Reset state: gnt suppressed even with req high, all outputs zero.
        repeat (2) step();
        obi_req.req = 1'b1;
        @(negedge clk_i);
        check_eq("rst.gnt",      32'(obi_rsp.gnt),    32'd0);
        check_eq("rst.rvalid",   32'(obi_rsp.rvalid), 32'd0);
        check_eq("rst.rdata",    obi_rsp.r.rdata,     32'h0000_0000);
        check_eq("rst.err",      32'(obi_rsp.r.err),  32'd0);
        check_eq("rst.reg_req",  32'(reg_req_o),      32'd0);
        check_eq("rst.reg_addr", 32'(reg_addr_o),     32'd0);
        check_eq("rst.reg_be",   32'(reg_be_o),       32'd0);
        check_eq("rst.reg_wdat", reg_wdata_o,         32'h0000_0000);
        step();
        obi_req.req = 1'b0;
        rst_i       = 1'b0;
        step();

        // Write with immediate ready; read data on the register side must not leak into a write.
        run_txn("wr2c", 32'h0000_002C, 1'b1, 4'b0010, 32'h0000_0400, 0,
                32'h1234_5678, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        // Read with three stalled ACCESS cycles.
        run_txn("rd30", 32'h0000_0030, 1'b0, 4'b1111, 32'h0000_0000, 3,
                32'h8001_0001, 1'b0, 1'b0, 32'h8001_0001, 1'b0);
        // Out-of-window read: filtered with error, rdata cleared.
        run_txn("rd100", 32'h0000_0100, 1'b0, 4'b1111, 32'h0000_0000, 0,
                32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
        // Empty byte enables: filtered without error.
        run_txn("rdbe0", 32'h0000_0024, 1'b0, 4'b0000, 32'h0000_0000, 0,
                32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
        // Unaligned address is word-aligned on the register side.
        run_txn("rd37", 32'h0000_0037, 1'b0, 4'b1000, 32'h0000_0000, 1,
                32'h0BAD_F00D, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);
        // Back-to-back grants with req held high.
        grant_gap("b2b_acc", 4'b1111, 3);
        grant_gap("b2b_flt", 4'b0000, 2);
        // Register-side error on a write.
        run_txn("wr20err", 32'h0000_0020, 1'b1, 4'b1111, 32'hA5A5_5A5A, 0,
                32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1);

        // Reset in the middle of an ACCESS.
        obi_req.req     = 1'b1;
        obi_req.a.addr  = 32'h0000_0034;
        obi_req.a.we    = 1'b0;
        obi_req.a.be    = 4'b1111;
        obi_req.a.wdata = 32'h0000_0000;
        reg_ready_i     = 1'b0;
        reg_error_i     = 1'b0;
        @(negedge clk_i);
        check_eq("mid.gnt", 32'(obi_rsp.gnt), 32'd1);
        step();
        obi_req.req = 1'b0;
        @(negedge clk_i);
        check_eq("mid.reg_req_pre", 32'(reg_req_o),  32'd1);
        check_eq("mid.reg_addr_pre", 32'(reg_addr_o), 32'h34);
        step();
        rst_i = 1'b1;
        #1;
        check_eq("mid.reg_req_async", 32'(reg_req_o),      32'd0);
        check_eq("mid.reg_addr_rst",  32'(reg_addr_o),     32'd0);
        check_eq("mid.reg_be_rst",    32'(reg_be_o),       32'd0);
        check_eq("mid.rvalid_rst",    32'(obi_rsp.rvalid), 32'd0);
        check_eq("mid.err_rst",       32'(obi_rsp.r.err),  32'd0);
        reg_ready_i = 1'b1;
        step();
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check_eq("mid.no_rvalid", 32'(obi_rsp.rvalid), 32'd0);
            check_eq("mid.no_reg_req", 32'(reg_req_o),     32'd0);
            step();
        end
        reg_ready_i = 1'b0;
        run_txn("post_rst", 32'h0000_0008, 1'b0, 4'b0011, 32'h0000_0000, 0,
                32'h0000_BEEF, 1'b0, 1'b0, 32'h0000_BEEF, 1'b0);

`ifdef SDHCI_OBI_BRIDGE_TIMEOUT_EN
        begin
            int hi;
            int seen;
            hi              = 0;
            seen            = 0;
            obi_req.req     = 1'b1;
            obi_req.a.addr  = 32'h0000_0044;
            obi_req.a.we    = 1'b0;
            obi_req.a.be    = 4'b1111;
            reg_ready_i     = 1'b0;
            reg_rdata_i     = 32'h1111_2222;
            @(negedge clk_i);
            check_eq("tmo.gnt", 32'(obi_rsp.gnt), 32'd1);
            step();
            obi_req.req = 1'b0;
            for (int k = 0; k < 12 && seen == 0; k++) begin
                @(negedge clk_i);
                if (obi_rsp.rvalid) begin
                    seen = 1;
                    check_eq("tmo.rdata",   obi_rsp.r.rdata,    32'hDEAD_BEEF);
                    check_eq("tmo.err",     32'(obi_rsp.r.err), 32'd1);
                    check_eq("tmo.reg_req", 32'(reg_req_o),     32'd0);
                end else if (reg_req_o) begin
                    hi++;
                end
                step();
            end
            check_eq("tmo.rvalid_seen", 32'(seen), 32'd1);
            check_eq("tmo.req_cycles",  32'(hi),   32'd4);
            repeat (2) step();
        end
`else
        // Without the watchdog a stalled access waits for as long as ready stays low.
        run_txn("hang", 32'h0000_0044, 1'b0, 4'b1111, 32'h0000_0000, 16,
                32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
